// File: rtl/csa_pipe_addsub.sv
// ---------------------------------------------------------------------------
// csa_pipe_addsub -- two-stage pipelined carry-select adder/subtractor.
//
// Stage 1 computes every segment twice, once for carry-in 0 and once for
// carry-in 1. The exception is segment 0, which uses the real carry-in.
// Stage 2 walks the segment chain, picks one sum per segment from the
// resolved carries, and registers result, carry-out and signed overflow.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of SEG
//   SEG    carry-select segment width; WIDTH/SEG must be >= 2
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   in_valid       operand bundle valid
//   in_ready       a bundle can be accepted this cycle
//   data_operandA  operand A
//   data_operandB  operand B
//   ctrl_sub       0 = A+B, 1 = A-B
//   out_valid      result bundle valid
//   out_ready      downstream takes the result this cycle
//   data_result    sum/difference (modulo 2^WIDTH)
//   cout           carry out of the MSB (for subtract, 1 = no borrow)
//   overflow       signed two's-complement overflow
//
// Optional feature (macro CSA_SATURATE_EN):
//   When the macro is defined, a result that overflows is clamped to max
//   positive or min negative, chosen by the sign of operand A. Overflow and
//   cout are still reported unchanged. When the macro is not defined, the
//   result wraps around.
// ---------------------------------------------------------------------------

// One carry-select segment. It produces the sum and carry-out for both
// possible carry-ins.
module csa_seg #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    output logic [SEG-1:0] sum0,
    output logic [SEG-1:0] sum1,
    output logic           c0,
    output logic           c1
);
    assign {c0, sum0} = {1'b0, a} + {1'b0, b};
    assign {c1, sum1} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, 1'b1};
endmodule

module csa_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             cout,
    output logic             overflow
);
    localparam int NSEG = WIDTH / SEG;

    // -----------------------------------------------------------------
    // Handshake: vld_pipe[1] is stage 1 occupancy, vld_pipe[2] is stage 2.
    // -----------------------------------------------------------------
    logic [2:1] vld_pipe;
    logic       s1_load;
    logic       s2_load;

    // s2 can take a bundle when it is empty or its bundle leaves this cycle.
    assign s2_load   = vld_pipe[1] & (~vld_pipe[2] | out_ready);
    // out_ready feeds in_ready combinationally, so a full pipe still
    // streams one bundle per cycle.
    assign in_ready  = ~vld_pipe[1] | ~vld_pipe[2] | out_ready;
    assign s1_load   = in_valid & in_ready;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else begin
            if (s1_load)      vld_pipe[1] <= 1'b1;
            else if (s2_load) vld_pipe[1] <= 1'b0;

            if (s2_load)        vld_pipe[2] <= 1'b1;
            else if (out_ready) vld_pipe[2] <= 1'b0;
        end
    end

    // -----------------------------------------------------------------
    // Operand prep: subtract is A + ~B + 1.
    // -----------------------------------------------------------------
    logic [WIDTH-1:0]           b_op;
    logic [NSEG-1:0][SEG-1:0]   a_seg;
    logic [NSEG-1:0][SEG-1:0]   b_seg;

    assign b_op  = ctrl_sub ? ~data_operandB : data_operandB;
    assign a_seg = data_operandA;
    assign b_seg = b_op;

    // Segment 0 sees the real carry-in, so it needs only one adder.
    logic [SEG-1:0] lo_sum;
    logic           lo_c;
    assign {lo_c, lo_sum} = {1'b0, a_seg[0]} + {1'b0, b_seg[0]} + {{SEG{1'b0}}, ctrl_sub};

    // Upper segments: one dual-sum instance per segment.
    logic [NSEG-1:1][SEG-1:0] seg_sum0;
    logic [NSEG-1:1][SEG-1:0] seg_sum1;
    logic [NSEG-1:1]          seg_c0;
    logic [NSEG-1:1]          seg_c1;

    for (genvar k = 1; k < NSEG; k++) begin : g_seg
        csa_seg #(.SEG(SEG)) u_seg (
            .a    (a_seg[k]),
            .b    (b_seg[k]),
            .sum0 (seg_sum0[k]),
            .sum1 (seg_sum1[k]),
            .c0   (seg_c0[k]),
            .c1   (seg_c1[k])
        );
    end

    // The carry into the MSB equals sum_msb ^ a_msb ^ b_msb. This recovers
    // the value for both carry-in cases without a separate (SEG-1)-bit adder.
    logic msbcin0;
    logic msbcin1;
    assign msbcin0 = seg_sum0[NSEG-1][SEG-1] ^ data_operandA[WIDTH-1] ^ b_op[WIDTH-1];
    assign msbcin1 = seg_sum1[NSEG-1][SEG-1] ^ data_operandA[WIDTH-1] ^ b_op[WIDTH-1];

    // -----------------------------------------------------------------
    // Stage 1 registers
    // -----------------------------------------------------------------
    logic [SEG-1:0]           s1_lo_sum;
    logic                     s1_lo_c;
    logic [NSEG-1:1][SEG-1:0] s1_sum0;
    logic [NSEG-1:1][SEG-1:0] s1_sum1;
    logic [NSEG-1:1]          s1_c0;
    logic [NSEG-1:1]          s1_c1;
    logic                     s1_msbcin0;
    logic                     s1_msbcin1;
`ifdef CSA_SATURATE_EN
    logic                     s1_sign;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_lo_sum  <= '0;
            s1_lo_c    <= 1'b0;
            s1_sum0    <= '0;
            s1_sum1    <= '0;
            s1_c0      <= '0;
            s1_c1      <= '0;
            s1_msbcin0 <= 1'b0;
            s1_msbcin1 <= 1'b0;
`ifdef CSA_SATURATE_EN
            s1_sign    <= 1'b0;
`endif
        end else if (s1_load) begin
            s1_lo_sum  <= lo_sum;
            s1_lo_c    <= lo_c;
            s1_sum0    <= seg_sum0;
            s1_sum1    <= seg_sum1;
            s1_c0      <= seg_c0;
            s1_c1      <= seg_c1;
            s1_msbcin0 <= msbcin0;
            s1_msbcin1 <= msbcin1;
`ifdef CSA_SATURATE_EN
            s1_sign    <= data_operandA[WIDTH-1];
`endif
        end
    end

    // -----------------------------------------------------------------
    // Stage 2: serial carry resolution and select
    // -----------------------------------------------------------------
    logic [NSEG-1:0][SEG-1:0] res_seg;
    logic                     sel;
    logic                     msbc;
    logic                     cout_nxt;
    logic                     ovf_nxt;
    logic [WIDTH-1:0]         res_nxt;

    always_comb begin
        res_seg    = '0;
        res_seg[0] = s1_lo_sum;
        sel        = s1_lo_c;
        msbc       = 1'b0;
        for (int k = 1; k < NSEG; k++) begin
            // The top segment's carry into the MSB is picked by the same sel.
            if (k == NSEG-1) msbc = sel ? s1_msbcin1 : s1_msbcin0;
            res_seg[k] = sel ? s1_sum1[k] : s1_sum0[k];
            sel        = sel ? s1_c1[k] : s1_c0[k];
        end
        cout_nxt = sel;
        ovf_nxt  = msbc ^ sel;
`ifdef CSA_SATURATE_EN
        // Overflow needs both operands to share a sign, so A's sign picks
        // the direction of the clamp.
        if (ovf_nxt)
            res_nxt = s1_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            res_nxt = res_seg;
`else
        res_nxt = res_seg;
`endif
    end

    // Output registers load only on advance, so they hold during a stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_result <= '0;
            cout        <= 1'b0;
            overflow    <= 1'b0;
        end else if (s2_load) begin
            data_result <= res_nxt;
            cout        <= cout_nxt;
            overflow    <= ovf_nxt;
        end
    end

endmodule
